aes_keyram_seq: RTL and testbench
=================================

AES_KEYRAM_SEQ -- requirements
Module: aes_keyram_seq

Interface
REQ-001 SHALL have parameter NR, default 10, meaning AES round count; legal values 10, 12, 14.
REQ-002 SHALL have parameter NSLOT, default 4, meaning number of independent key schedules stored; legal values 1..8.
REQ-003 SHALL have derived parameter SW = max(1, clog2(NSLOT)) for the slot index width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 kill_n  in  1  asynchronous active-low reset.
REQ-006 kill  in  1  synchronous abort; high clears the sequencer.
REQ-007 en_wr  in  1  round-key write strobe.
REQ-008 slot_wr  in  SW  slot written.
REQ-009 addr_wr  in  4  round index written, 0..NR.
REQ-010 key_round_wr  in  128  round-key write data.
REQ-011 start  in  1  begin a read sequence on slot_sel.
REQ-012 slot_sel  in  SW  slot read by start.
REQ-013 key_ready  in  1  consumer request for the next round key.
REQ-014 key_round_rd  out  128  current round key.
REQ-015 key_valid  out  1  key_round_rd holds a valid key.
REQ-016 key_last  out  1  key_round_rd is round NR.
REQ-017 busy  out  1  sequencer is not IDLE.
REQ-018 wr_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-019 Storage SHALL be NSLOT*(NR+1) words of 128 bits, addressed as slot*(NR+1)+round, with one write port and one registered read port.
REQ-020 FSM SHALL have two states: IDLE and RUN.
REQ-021 IDLE with start: capture slot_sel, issue a read of round 0, go to RUN; key_round_rd and key_valid=1 SHALL appear on the next edge (1-cycle latency).
REQ-022 RUN with key_ready and round<NR: round increments, next word is read, and it is presented 1 cycle later.
REQ-023 key_last SHALL be asserted together with round NR data.
REQ-024 RUN with key_ready while key_last=1: go to IDLE and clear key_valid and key_last; key_round_rd keeps its last value.
REQ-025 start SHALL be ignored in RUN; key_ready SHALL be ignored in IDLE.
REQ-026 A write SHALL be accepted when addr_wr<=NR, and it is either in IDLE or slot_wr differs from the active slot.
REQ-027 Any other write SHALL be dropped and wr_err pulsed for 1 cycle.
REQ-028 A write and a read in the same cycle SHALL both proceed.
REQ-029 A same-address write and read in the same cycle SHALL return the old data (read-first).
REQ-030 slot_sel or slot_wr >= NSLOT SHALL be treated as an illegal access: start is ignored; a write is dropped and wr_err pulsed.
REQ-031 kill SHALL have priority over start and key_ready.
REQ-032 kill SHALL cause, on the next edge: IDLE, round=0, key_round_rd=0, key_valid=0, key_last=0; RAM is untouched.

Reset
REQ-033 kill_n low SHALL asynchronously force: IDLE, round=0, active slot=0, key_round_rd=0, key_valid=0, key_last=0, busy=0, wr_err=0.
REQ-034 RAM contents SHALL NOT be reset.
REQ-035 Reset asserted mid-sequence SHALL abandon that sequence; the first start after deassertion SHALL restart at round 0.

Configuration
REQ-036 Macro AES_KEYRAM_PARITY_EN defined: each word SHALL store one even-parity bit per byte (16 bits), checked on read.
REQ-037 With AES_KEYRAM_PARITY_EN defined, output par_err (1 bit) SHALL pulse together with key_valid data whose parity mismatches; par_err resets to 0.
REQ-038 Macro undefined: no parity storage, no par_err port, behaviour otherwise identical.

Structure
REQ-039 A shared package aes_pkg SHALL hold the AES_KW=128 constant, the NR legal values, the FSM state enum and a round-index typedef.
REQ-040 The storage SHALL be one sub-module, aes_keyram_bank (simple dual-port, read-first, registered output); the FSM, address arithmetic and checks SHALL stay in aes_keyram_seq.

Verification
REQ-041 Load the FIPS-197 C.1 schedule into slot 2 (NR=10), then start with slot_sel=2 and pulse key_ready 10 times -> round 0 = 0f0e0d0c0b0a09080706050403020100 one cycle after start, round 10 = c5302b4d8ba707f3174a94e37f1d1113 with key_last=1; an 11th key_ready -> busy=0.
REQ-042 In RUN on slot 2, write slot_wr=2 addr_wr=3 -> wr_err=1 for 1 cycle and the slot 2 round 3 data is unchanged; write slot_wr=1 -> accepted with no wr_err.
REQ-043 Assert kill at round 5 together with key_ready -> next cycle key_round_rd=0, key_valid=0, busy=0; a new start returns round 0.
REQ-044 Drop kill_n asynchronously mid-cycle during RUN -> outputs are 0 immediately; after release, slot contents are preserved.
REQ-045 NR=14, NSLOT=8: fill slot 7 with rounds 0..14 and sequence it -> 15 keys in order, key_last on the 15th; a write with addr_wr=15 -> wr_err.
REQ-046 With AES_KEYRAM_PARITY_EN defined, force a flipped bit in a stored word -> par_err=1 in the same cycle that word is presented.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-RAM definitions: word width, legal round counts, sequencer state and round index.
// Byte parity helper is used only when AES_KEYRAM_PARITY_EN is defined.
package aes_pkg;

    localparam int AES_KW     = 128;
    localparam int AES_PW     = AES_KW / 8;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    typedef logic [3:0] round_t;

    // Even parity per byte: the stored bit makes each byte plus its bit hold an even count of ones.
    function automatic logic [AES_PW-1:0] byte_parity(input logic [AES_KW-1:0] w);
        logic [AES_PW-1:0] p;
        for (int i = 0; i < AES_PW; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_keyram_seq_if.sv
// Write bus and round-key stream of aes_keyram_seq; par_err exists only with AES_KEYRAM_PARITY_EN.
interface aes_keyram_seq_if #(
    parameter int SW = 2
);
    import aes_pkg::*;

    logic              en_wr;
    logic [SW-1:0]     slot_wr;
    logic [3:0]        addr_wr;
    logic [AES_KW-1:0] key_round_wr;
    logic              wr_err;

    logic              start;
    logic [SW-1:0]     slot_sel;
    logic              key_ready;
    logic [AES_KW-1:0] key_round_rd;
    logic              key_valid;
    logic              key_last;
    logic              busy;
`ifdef AES_KEYRAM_PARITY_EN
    logic              par_err;

    modport master (
        output en_wr, slot_wr, addr_wr, key_round_wr, start, slot_sel, key_ready,
        input  wr_err, key_round_rd, key_valid, key_last, busy, par_err
    );
    modport slave (
        input  en_wr, slot_wr, addr_wr, key_round_wr, start, slot_sel, key_ready,
        output wr_err, key_round_rd, key_valid, key_last, busy, par_err
    );
`else
    modport master (
        output en_wr, slot_wr, addr_wr, key_round_wr, start, slot_sel, key_ready,
        input  wr_err, key_round_rd, key_valid, key_last, busy
    );
    modport slave (
        input  en_wr, slot_wr, addr_wr, key_round_wr, start, slot_sel, key_ready,
        output wr_err, key_round_rd, key_valid, key_last, busy
    );
`endif

endinterface

// File: rtl/aes_keyram_bank.sv
// Simple dual-port key storage, read-first, registered read data with reset and synchronous clear.
// The array itself is never reset so stored schedules survive kill and kill_n.
module aes_keyram_bank #(
    parameter int DEPTH = 44,
    parameter int W     = 128,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Sampling mem here before the write lands gives old data on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/aes_keyram_seq.sv
// Multi-slot AES round-key RAM with a round sequencer streaming keys 0..NR of one slot.
// Define AES_KEYRAM_PARITY_EN to store per-byte parity and raise par_err on a bad word.
//
// state    | meaning
// SEQ_IDLE | no sequence; start on a legal slot reads round 0
// SEQ_RUN  | key_round_rd holds round 'round' of act_slot; key_ready advances
module aes_keyram_seq
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int NSLOT = 4,
    parameter int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic            clk,
    input  logic            kill_n,
    input  logic            kill,
    aes_keyram_seq_if.slave bus
);

    localparam int NW = NSLOT * (NR + 1);
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;
`ifdef AES_KEYRAM_PARITY_EN
    localparam int WW = AES_KW + AES_PW;
`else
    localparam int WW = AES_KW;
`endif

    seq_state_t    state, state_nx;
    round_t        round, round_nx;
    logic [SW-1:0] act_slot, slot_nx;
    logic          key_valid_q, valid_nx;
    logic          key_last_q, last_nx;
    logic          wr_err_q;

    logic          rd_en, rd_clr;
    round_t        rd_round;
    logic [SW-1:0] rd_slot;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          sel_ok, wslot_ok, wr_ok;
    logic [WW-1:0] wr_word, rd_word;

    assign sel_ok   = 32'(bus.slot_sel) < NSLOT;
    assign wslot_ok = 32'(bus.slot_wr) < NSLOT;

    // The slot being streamed is write-protected until the sequence ends.
    assign wr_ok = bus.en_wr && (bus.addr_wr <= 4'(NR)) && wslot_ok
                   && ((state == SEQ_IDLE) || (bus.slot_wr != act_slot));

    assign wr_addr = AW'(bus.slot_wr) * AW'(NR + 1) + AW'(bus.addr_wr);
    assign rd_addr = AW'(rd_slot) * AW'(NR + 1) + AW'(rd_round);

    always_comb begin
        state_nx = state;
        round_nx = round;
        slot_nx  = act_slot;
        valid_nx = key_valid_q;
        last_nx  = key_last_q;
        rd_en    = 1'b0;
        rd_clr   = 1'b0;
        rd_round = round;
        rd_slot  = act_slot;
        if (kill) begin
            state_nx = SEQ_IDLE;
            round_nx = '0;
            valid_nx = 1'b0;
            last_nx  = 1'b0;
            rd_clr   = 1'b1;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (bus.start && sel_ok) begin
                        state_nx = SEQ_RUN;
                        slot_nx  = bus.slot_sel;
                        round_nx = '0;
                        rd_en    = 1'b1;
                        rd_slot  = bus.slot_sel;
                        rd_round = '0;
                        valid_nx = 1'b1;
                        last_nx  = 1'b0;
                    end
                end
                SEQ_RUN: begin
                    if (bus.key_ready) begin
                        if (key_last_q) begin
                            state_nx = SEQ_IDLE;
                            valid_nx = 1'b0;
                            last_nx  = 1'b0;
                        end else begin
                            round_nx = round + 4'd1;
                            rd_en    = 1'b1;
                            rd_round = round_nx;
                            last_nx  = (round_nx == 4'(NR));
                        end
                    end
                end
                default: state_nx = SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state       <= SEQ_IDLE;
            round       <= '0;
            act_slot    <= '0;
            key_valid_q <= 1'b0;
            key_last_q  <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state       <= state_nx;
            round       <= round_nx;
            act_slot    <= slot_nx;
            key_valid_q <= valid_nx;
            key_last_q  <= last_nx;
            wr_err_q    <= bus.en_wr && !wr_ok;
        end
    end

`ifdef AES_KEYRAM_PARITY_EN
    assign wr_word          = {byte_parity(bus.key_round_wr), bus.key_round_wr};
    assign bus.key_round_rd = rd_word[AES_KW-1:0];
    assign bus.par_err      = key_valid_q
                              && (byte_parity(rd_word[AES_KW-1:0]) != rd_word[WW-1:AES_KW]);
`else
    assign wr_word          = bus.key_round_wr;
    assign bus.key_round_rd = rd_word;
`endif

    assign bus.key_valid = key_valid_q;
    assign bus.key_last  = key_last_q;
    assign bus.busy      = (state == SEQ_RUN);
    assign bus.wr_err    = wr_err_q;

    aes_keyram_bank #(
        .DEPTH (NW),
        .W     (WW),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .rst_n (kill_n),
        .clr   (rd_clr),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_aes_keyram_seq.sv
// Directed bench for aes_keyram_seq: NR=10/NSLOT=4, NR=14/NSLOT=8 and NSLOT=3 instances.
// Parity checks are compiled only with AES_KEYRAM_PARITY_EN.
module tb_aes_keyram_seq;
    import aes_pkg::*;

    logic clk;
    logic kill_n;
    logic kill;
    int   n_vec;
    int   n_err;

    aes_keyram_seq_if #(.SW(2)) bus_a ();
    aes_keyram_seq_if #(.SW(3)) bus_b ();
    aes_keyram_seq_if #(.SW(2)) bus_c ();

    aes_keyram_seq #(.NR(10), .NSLOT(4)) dut_a (.clk(clk), .kill_n(kill_n), .kill(kill), .bus(bus_a.slave));
    aes_keyram_seq #(.NR(14), .NSLOT(8)) dut_b (.clk(clk), .kill_n(kill_n), .kill(kill), .bus(bus_b.slave));
    aes_keyram_seq #(.NR(10), .NSLOT(3)) dut_c (.clk(clk), .kill_n(kill_n), .kill(kill), .bus(bus_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] fips [0:10];
    localparam logic [127:0] R0_EXP  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] R10_EXP = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    localparam logic [127:0] NEW0    = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] NEW3    = 128'hdeadbeef_cafef00d_01020304_a5a55a5a;

    function automatic logic [127:0] bswap(input logic [127:0] w);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = w[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] pat1(input int r);
        return {4{32'h1111_0000 + 32'(r)}};
    endfunction

    function automatic logic [127:0] patb(input int r);
        return {4{32'hb700_0000 + 32'(r)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [1:0] s, input logic [3:0] a, input logic [127:0] d);
        bus_a.en_wr = 1'b1; bus_a.slot_wr = s; bus_a.addr_wr = a; bus_a.key_round_wr = d;
        tick();
        bus_a.en_wr = 1'b0;
    endtask

    task automatic pulse_ready_a();
        bus_a.key_ready = 1'b1;
        tick();
        bus_a.key_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        fips[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        fips[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        fips[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        fips[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        fips[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        fips[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        fips[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        fips[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        fips[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        fips[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        kill_n = 1'b0;
        kill   = 1'b0;
        bus_a.en_wr = 0; bus_a.slot_wr = 0; bus_a.addr_wr = 0; bus_a.key_round_wr = 0;
        bus_a.start = 0; bus_a.slot_sel = 0; bus_a.key_ready = 0;
        bus_b.en_wr = 0; bus_b.slot_wr = 0; bus_b.addr_wr = 0; bus_b.key_round_wr = 0;
        bus_b.start = 0; bus_b.slot_sel = 0; bus_b.key_ready = 0;
        bus_c.en_wr = 0; bus_c.slot_wr = 0; bus_c.addr_wr = 0; bus_c.key_round_wr = 0;
        bus_c.start = 0; bus_c.slot_sel = 0; bus_c.key_ready = 0;

        // reset state
        #2;
        chk("rst_valid", bus_a.key_valid, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_last", bus_a.key_last, 0);
        chk("rst_wr_err", bus_a.wr_err, 0);
        chk("rst_rd", bus_a.key_round_rd, 0);
        tick(); tick();
        kill_n = 1'b1;
        tick();

        // load FIPS-197 C.1 into slot 2 and a pattern into slot 1
        for (int r = 0; r <= 10; r++) begin
            wr_a(2'd2, 4'(r), bswap(fips[r]));
            wr_a(2'd1, 4'(r), pat1(r));
        end
        chk("load_wr_err", bus_a.wr_err, 0);
        wr_a(2'd2, 4'd11, '1);
        chk("addr11_wr_err", bus_a.wr_err, 1);
        tick();
        chk("wr_err_pulse_end", bus_a.wr_err, 0);

        // full sequence on slot 2
        bus_a.start = 1'b1; bus_a.slot_sel = 2'd2;
        tick();
        bus_a.start = 1'b0;
        chk("seq_r0", bus_a.key_round_rd, R0_EXP);
        chk("seq_r0_valid", bus_a.key_valid, 1);
        chk("seq_r0_busy", bus_a.busy, 1);
        chk("seq_r0_last", bus_a.key_last, 0);
`ifdef AES_KEYRAM_PARITY_EN
        chk("par_clean", bus_a.par_err, 0);
`endif
        for (int r = 1; r <= 10; r++) begin
            bus_a.key_ready = 1'b1;
            if (r == 3) begin
                bus_a.en_wr = 1'b1; bus_a.slot_wr = 2'd1; bus_a.addr_wr = 4'd3; bus_a.key_round_wr = NEW3;
            end
            if (r == 5) begin
                bus_a.start = 1'b1; bus_a.slot_sel = 2'd1;
            end
            tick();
            bus_a.key_ready = 1'b0; bus_a.en_wr = 1'b0; bus_a.start = 1'b0;
            chk($sformatf("seq_r%0d", r), bus_a.key_round_rd, bswap(fips[r]));
            chk($sformatf("seq_last_r%0d", r), bus_a.key_last, 128'(r == 10));
            if (r == 3) chk("other_slot_wr_err", bus_a.wr_err, 0);
            if (r == 2) begin
                wr_a(2'd2, 4'd3, '1);
                chk("active_slot_wr_err", bus_a.wr_err, 1);
            end
        end
        chk("seq_r10_lit", bus_a.key_round_rd, R10_EXP);
        pulse_ready_a();
        chk("end_busy", bus_a.busy, 0);
        chk("end_valid", bus_a.key_valid, 0);
        chk("end_last", bus_a.key_last, 0);
        chk("end_rd_hold", bus_a.key_round_rd, R10_EXP);
        pulse_ready_a();
        chk("idle_ready_busy", bus_a.busy, 0);
        chk("idle_ready_valid", bus_a.key_valid, 0);

        // kill at round 5 together with key_ready
        bus_a.start = 1'b1; bus_a.slot_sel = 2'd2;
        tick();
        bus_a.start = 1'b0;
        for (int r = 1; r <= 5; r++) pulse_ready_a();
        chk("kill_pre_r5", bus_a.key_round_rd, bswap(fips[5]));
        kill = 1'b1; bus_a.key_ready = 1'b1;
        tick();
        kill = 1'b0; bus_a.key_ready = 1'b0;
        chk("kill_rd", bus_a.key_round_rd, 0);
        chk("kill_valid", bus_a.key_valid, 0);
        chk("kill_busy", bus_a.busy, 0);
        chk("kill_last", bus_a.key_last, 0);

        // restart on slot 1 with a colliding write to round 0: old data is returned
        bus_a.start = 1'b1; bus_a.slot_sel = 2'd1;
        bus_a.en_wr = 1'b1; bus_a.slot_wr = 2'd1; bus_a.addr_wr = 4'd0; bus_a.key_round_wr = NEW0;
        tick();
        bus_a.start = 1'b0; bus_a.en_wr = 1'b0;
        chk("read_first", bus_a.key_round_rd, pat1(0));
        chk("collide_wr_err", bus_a.wr_err, 0);
        for (int r = 1; r <= 3; r++) pulse_ready_a();
        chk("slot1_r3_new", bus_a.key_round_rd, NEW3);
        kill = 1'b1;
        tick();
        kill = 1'b0;

        // asynchronous kill_n mid-sequence
        bus_a.start = 1'b1; bus_a.slot_sel = 2'd2;
        tick();
        bus_a.start = 1'b0;
        pulse_ready_a();
        chk("pre_rstn_r1", bus_a.key_round_rd, bswap(fips[1]));
        #3;
        kill_n = 1'b0;
        #1;
        chk("rstn_rd", bus_a.key_round_rd, 0);
        chk("rstn_valid", bus_a.key_valid, 0);
        chk("rstn_busy", bus_a.busy, 0);
        tick();
        kill_n = 1'b1;
        tick();
        bus_a.start = 1'b1; bus_a.slot_sel = 2'd1;
        tick();
        bus_a.start = 1'b0;
        chk("rstn_keep_slot1", bus_a.key_round_rd, NEW0);
        kill = 1'b1; tick(); kill = 1'b0;
        bus_a.start = 1'b1; bus_a.slot_sel = 2'd2;
        tick();
        bus_a.start = 1'b0;
        chk("rstn_keep_slot2", bus_a.key_round_rd, R0_EXP);
        kill = 1'b1; tick(); kill = 1'b0;

        // NR=14, NSLOT=8 on slot 7
        for (int r = 0; r <= 14; r++) begin
            bus_b.en_wr = 1'b1; bus_b.slot_wr = 3'd7; bus_b.addr_wr = 4'(r); bus_b.key_round_wr = patb(r);
            tick();
        end
        bus_b.en_wr = 1'b0;
        chk("b_load_wr_err", bus_b.wr_err, 0);
        bus_b.en_wr = 1'b1; bus_b.slot_wr = 3'd7; bus_b.addr_wr = 4'd15; bus_b.key_round_wr = '1;
        tick();
        bus_b.en_wr = 1'b0;
        chk("b_addr15_wr_err", bus_b.wr_err, 1);
        bus_b.start = 1'b1; bus_b.slot_sel = 3'd7;
        tick();
        bus_b.start = 1'b0;
        chk("b_r0", bus_b.key_round_rd, patb(0));
        chk("b_r0_last", bus_b.key_last, 0);
        for (int r = 1; r <= 14; r++) begin
            bus_b.key_ready = 1'b1;
            tick();
            bus_b.key_ready = 1'b0;
            chk($sformatf("b_r%0d", r), bus_b.key_round_rd, patb(r));
            chk($sformatf("b_last_r%0d", r), bus_b.key_last, 128'(r == 14));
        end
        bus_b.key_ready = 1'b1;
        tick();
        bus_b.key_ready = 1'b0;
        chk("b_end_busy", bus_b.busy, 0);

        // NSLOT=3: slot index 3 is illegal
        bus_c.en_wr = 1'b1; bus_c.slot_wr = 2'd3; bus_c.addr_wr = 4'd0; bus_c.key_round_wr = 128'hbad;
        tick();
        bus_c.en_wr = 1'b0;
        chk("c_bad_slot_wr_err", bus_c.wr_err, 1);
        bus_c.en_wr = 1'b1; bus_c.slot_wr = 2'd2; bus_c.addr_wr = 4'd0; bus_c.key_round_wr = 128'hc2;
        tick();
        bus_c.en_wr = 1'b0;
        chk("c_good_slot_wr_err", bus_c.wr_err, 0);
        bus_c.start = 1'b1; bus_c.slot_sel = 2'd3;
        tick();
        bus_c.start = 1'b0;
        chk("c_bad_start_busy", bus_c.busy, 0);
        chk("c_bad_start_valid", bus_c.key_valid, 0);
        bus_c.start = 1'b1; bus_c.slot_sel = 2'd2;
        tick();
        bus_c.start = 1'b0;
        chk("c_good_start_valid", bus_c.key_valid, 1);
        chk("c_good_start_rd", bus_c.key_round_rd, 128'hc2);

`ifdef AES_KEYRAM_PARITY_EN
        // slot 2 round 0 lives at word 2*11+0
        dut_a.u_bank.mem[22] = dut_a.u_bank.mem[22] ^ 144'h1;
        bus_a.start = 1'b1; bus_a.slot_sel = 2'd2;
        tick();
        bus_a.start = 1'b0;
        chk("par_err_flip", bus_a.par_err, 1);
        chk("par_err_valid", bus_a.key_valid, 1);
        pulse_ready_a();
        chk("par_err_next_clean", bus_a.par_err, 0);
        kill = 1'b1; tick(); kill = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
